// File: rtl/viterbi_pkg.sv
// Shared convolutional-code constants for the K=3, rate-1/2 encoder and the
// matching Viterbi decoder, plus the framing FSM state type.
package viterbi_pkg;

    // Constraint length and generator polynomials over {d, sr[0], sr[1]}.
    localparam int            K  = 3;
    localparam logic [K-1:0]  G1 = 3'b111;
    localparam logic [K-1:0]  G0 = 3'b101;

    // Width of the per-frame data bit counter.
    localparam int            CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    // Symbol for bit d given history sr; the window is ordered {d, sr[0], sr[1]}
    // so the MSB of each generator taps the current bit.
    function automatic logic [1:0] conv_symbol(input logic d, input logic [K-2:0] sr);
        logic [K-1:0] window;
        window = {d, sr[0], sr[1]};
        return {^(window & G1), ^(window & G0)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder core: two-bit history register plus the generator XOR network.
// The symbol output is combinational; the caller registers it.
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       d,
    output logic [1:0] sym_o
);

    logic [K-2:0] sr_q;
    logic [K-2:0] sr_d;

    // Shift the new bit in only when a symbol is actually produced.
    always_comb begin
        sr_d = sr_q;
        if (advance) begin
            sr_d = {sr_q[0], d};
        end
    end

    assign sym_o = conv_symbol(d, sr_q);

    // History register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed convolutional encoder: accepts FRAME_LEN data bits, then appends
// K-1 zero tail bits so every frame leaves the encoder in the zero state.
module conv_encoder_framed
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       frame_start_o,
    output logic       frame_end_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    enc_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tail_q, tail_d;      // set while emitting the second tail symbol

    logic             advance;
    logic             enc_bit;
    logic             start_sym;
    logic             end_sym;
    logic [1:0]       sym;

    logic             valid_q;
    logic [1:0]       d_out_q;
    logic             frame_start_q;
    logic             frame_end_q;

    conv_enc_core u_core (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .d       (enc_bit),
        .sym_o   (sym)
    );

    // Ready depends on the state alone, never on enable_i.
    assign ready_o = (state_q != TAIL);

    // Framing FSM: next state, counter and per-cycle symbol control.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tail_d    = tail_q;
        advance   = 1'b0;
        enc_bit   = 1'b0;
        start_sym = 1'b0;
        end_sym   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    advance   = 1'b1;
                    enc_bit   = d_in;
                    start_sym = 1'b1;
                    count_d   = CNT_W'(1);
                    tail_d    = 1'b0;
                    state_d   = (LAST_CNT == CNT_W'(1)) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (enable_i) begin
                    advance = 1'b1;
                    enc_bit = d_in;
                    count_d = count_q + CNT_W'(1);
                    if (count_d == LAST_CNT) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                // Input is ignored; flush zeros through the history register.
                advance = 1'b1;
                enc_bit = 1'b0;
                if (tail_q) begin
                    end_sym = 1'b1;
                    tail_d  = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    tail_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                tail_d  = 1'b0;
            end
        endcase
    end

    // FSM state register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tail_q  <= tail_d;
        end
    end

    // Output registers; the symbol only updates when one is produced so that
    // idle cycles never reflect d_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            d_out_q       <= 2'b00;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            valid_q       <= advance;
            frame_start_q <= start_sym;
            frame_end_q   <= end_sym;
            if (advance) begin
                d_out_q <= sym;
            end
        end
    end

    assign valid_o       = valid_q;
    assign d_out         = d_out_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Bench for conv_encoder_framed: directed vector table on a FRAME_LEN=4
// instance, a hand sequence on a FRAME_LEN=1 instance, then random
// back-to-back frames checked against an array-based code model and decoded.
module tb_conv_encoder_framed;

    logic       clk = 1'b0;
    logic       rst;
    logic       en4, d4, en1, d1;
    logic       ready4, valid4, start4, end4;
    logic       ready1, valid1, start1, end1;
    logic [1:0] dout4, dout1;

    always #5 clk = ~clk;

    conv_encoder_framed #(.FRAME_LEN(4)) u_dut4 (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (en4),
        .d_in          (d4),
        .ready_o       (ready4),
        .valid_o       (valid4),
        .d_out         (dout4),
        .frame_start_o (start4),
        .frame_end_o   (end4)
    );

    conv_encoder_framed #(.FRAME_LEN(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (en1),
        .d_in          (d1),
        .ready_o       (ready1),
        .valid_o       (valid1),
        .d_out         (dout1),
        .frame_start_o (start1),
        .frame_end_o   (end1)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each row: inputs applied for one cycle, ready expected during that
    // cycle, and the registered outputs expected one edge later.
    typedef struct {
        logic       rst;
        logic       en;
        logic       d;
        logic       ready;
        logic       valid;
        logic [1:0] dout;
        logic       start;
        logic       fend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic d, input logic rdy,
                       input logic v, input logic [1:0] o, input logic s, input logic fe);
        vec_t x;
        x.rst = r; x.en = e; x.d = d; x.ready = rdy;
        x.valid = v; x.dout = o; x.start = s; x.fend = fe;
        vecs.push_back(x);
    endtask

    // Frame 1,0,1,1 from zero state: 11,10,00,01 then tail 01,11.
    task automatic add_frame_a();
        add(0, 1, 1, 1, 1, 2'b11, 1, 0);
        add(0, 1, 0, 1, 1, 2'b10, 0, 0);
        add(0, 1, 1, 1, 1, 2'b00, 0, 0);
        add(0, 1, 1, 1, 1, 2'b01, 0, 0);
    endtask

    // Random-phase reference data and monitor state.
    logic [5:0] exp_q[$];     // {start, end, symbol}
    logic [3:0] in_q[$];      // data bits of each frame, bit i = i-th bit sent
    logic       rand_on = 1'b0;
    logic [3:0] cur_frame;
    logic       dec_p1, dec_p2;
    int         dec_idx;

    // Random-phase monitor: compare each symbol and invert the code to
    // recover the data (error-free channel, so decisions are exact).
    always @(negedge clk) begin
        if (rand_on && valid4) begin
            if (exp_q.size() == 0) begin
                check("rand_extra_symbol", 8'd1, 8'd0);
            end else begin
                logic [5:0] e;
                logic       bit_dec;
                e = exp_q.pop_front();
                check("rand_symbol", {2'b00, start4, end4, dout4}, {2'b00, e});
                if (start4) begin
                    dec_p1  = 1'b0;
                    dec_p2  = 1'b0;
                    dec_idx = 0;
                    if (in_q.size() > 0) cur_frame = in_q.pop_front();
                end
                bit_dec = dout4[0] ^ dec_p2;
                if (dec_idx < 4) begin
                    check("decoded_bit", {7'd0, bit_dec}, {7'd0, cur_frame[dec_idx]});
                end
                dec_p2 = dec_p1;
                dec_p1 = bit_dec;
                dec_idx++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en4 = 1'b0; d4 = 1'b0; en1 = 1'b0; d1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with enable high: ignored, outputs cleared.
        add(1, 1, 1, 1, 0, 2'b00, 0, 0);
        add(1, 1, 0, 1, 0, 2'b00, 0, 0);
        // Basic frame; ready low for exactly the two tail cycles.
        add_frame_a();
        add(0, 0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 1, 2'b11, 0, 1);
        add(0, 0, 1, 1, 0, 2'b00, 0, 0);
        // Same frame with a 3-cycle gap after the second bit.
        add(0, 1, 1, 1, 1, 2'b11, 1, 0);
        add(0, 1, 0, 1, 1, 2'b10, 0, 0);
        add(0, 0, 1, 1, 0, 2'b00, 0, 0);
        add(0, 0, 0, 1, 0, 2'b00, 0, 0);
        add(0, 0, 1, 1, 0, 2'b00, 0, 0);
        add(0, 1, 1, 1, 1, 2'b00, 0, 0);
        add(0, 1, 1, 1, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 1, 2'b11, 0, 1);
        // Enable held high with random data through the tail, then the next
        // frame (0,1,1,0 -> 00,11,01,01,11,00) starts immediately.
        add_frame_a();
        add(0, 1, 1'($urandom_range(0, 1)), 0, 1, 2'b01, 0, 0);
        add(0, 1, 1'($urandom_range(0, 1)), 0, 1, 2'b11, 0, 1);
        add(0, 1, 0, 1, 1, 2'b00, 1, 0);
        add(0, 1, 1, 1, 1, 2'b11, 0, 0);
        add(0, 1, 1, 1, 1, 2'b01, 0, 0);
        add(0, 1, 0, 1, 1, 2'b01, 0, 0);
        add(0, 1, 1'($urandom_range(0, 1)), 0, 1, 2'b11, 0, 0);
        add(0, 1, 1'($urandom_range(0, 1)), 0, 1, 2'b00, 0, 1);
        // Reset after the second symbol: no tail, next frame from zero state.
        add(0, 1, 1, 1, 1, 2'b11, 1, 0);
        add(0, 1, 0, 1, 1, 2'b10, 0, 0);
        add(1, 1, 1, 1, 0, 2'b00, 0, 0);
        add_frame_a();
        add(0, 0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 1, 2'b11, 0, 1);
        // Reset in the first tail cycle: no tail symbol, ready back at once.
        add_frame_a();
        add(1, 0, 0, 0, 0, 2'b00, 0, 0);
        add(0, 0, 1, 1, 0, 2'b00, 0, 0);
        add(0, 1, 0, 1, 1, 2'b00, 1, 0);
        add(0, 1, 1, 1, 1, 2'b11, 0, 0);
        add(0, 1, 1, 1, 1, 2'b01, 0, 0);
        add(0, 1, 0, 1, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 1, 2'b11, 0, 0);
        add(0, 0, 0, 0, 1, 2'b00, 0, 1);
        add(0, 0, 0, 1, 0, 2'b00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en4 = vecs[i].en; d4 = vecs[i].d;
            #1;
            check($sformatf("vec%0d_ready", i), {7'd0, ready4}, {7'd0, vecs[i].ready});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {7'd0, valid4}, {7'd0, vecs[i].valid});
            check($sformatf("vec%0d_flags", i), {6'd0, start4, end4},
                  {6'd0, vecs[i].start, vecs[i].fend});
            if (vecs[i].valid || vecs[i].rst) begin
                check($sformatf("vec%0d_dout", i), {6'd0, dout4}, {6'd0, vecs[i].dout});
            end
        end
        rst = 1'b0; en4 = 1'b0; d4 = 1'b0;

        // FRAME_LEN=1, bit 1: generator equations give 11, 10, 11.
        en1 = 1'b1; d1 = 1'b1;
        #1;
        check("len1_ready_idle", {7'd0, ready1}, 8'd1);
        @(posedge clk); #1;
        en1 = 1'b1; d1 = 1'b1;   // ignored during tail
        check("len1_sym0", {4'd0, valid1, start1, end1, 1'b0}, 8'b0000_1100);
        check("len1_d0", {6'd0, dout1}, 8'b11);
        check("len1_ready_t0", {7'd0, ready1}, 8'd0);
        @(posedge clk); #1;
        check("len1_sym1", {4'd0, valid1, start1, end1, 1'b0}, 8'b0000_1000);
        check("len1_d1", {6'd0, dout1}, 8'b10);
        check("len1_ready_t1", {7'd0, ready1}, 8'd0);
        en1 = 1'b0; d1 = 1'b0;
        @(posedge clk); #1;
        check("len1_sym2", {4'd0, valid1, start1, end1, 1'b0}, 8'b0000_1010);
        check("len1_d2", {6'd0, dout1}, 8'b11);
        check("len1_ready_idle2", {7'd0, ready1}, 8'd1);
        @(posedge clk); #1;
        check("len1_quiet", {7'd0, valid1}, 8'd0);

        // Random frames with random gaps and enable toggling in the tail.
        rand_on = 1'b1;
        for (int f = 0; f < 256; f++) begin
            logic [3:0] bits;
            logic       bb[8];
            bits = 4'($urandom_range(0, 15));
            in_q.push_back(bits);
            // Code model: each symbol is a sliding window over the zero-padded
            // bit sequence (two zeros before, two tail zeros after).
            bb[0] = 1'b0; bb[1] = 1'b0; bb[6] = 1'b0; bb[7] = 1'b0;
            for (int i = 0; i < 4; i++) bb[i + 2] = bits[i];
            for (int n = 0; n < 6; n++) begin
                logic x, p1, p2;
                x = bb[n + 2]; p1 = bb[n + 1]; p2 = bb[n];
                exp_q.push_back({(n == 0), (n == 5), x ^ p1 ^ p2, x ^ p2});
            end
            for (int i = 0; i < 4; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    en4 = 1'b0; d4 = 1'($urandom_range(0, 1));
                    #1;
                    check("rand_ready_gap", {7'd0, ready4}, 8'd1);
                    @(posedge clk); #1;
                end
                en4 = 1'b1; d4 = bits[i];
                #1;
                check("rand_ready_data", {7'd0, ready4}, 8'd1);
                @(posedge clk); #1;
            end
            for (int t = 0; t < 2; t++) begin
                en4 = 1'($urandom_range(0, 1)); d4 = 1'($urandom_range(0, 1));
                #1;
                check("rand_ready_tail", {7'd0, ready4}, 8'd0);
                @(posedge clk); #1;
            end
        end
        en4 = 1'b0; d4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rand_on = 1'b0;
        check("rand_symbols_left", 8'(exp_q.size()), 8'd0);
        check("rand_frames_left", 8'(in_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
